// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode-stage instruction tags in, stall/forward controls out.
//   d_read_addr0/1   rs/rt addresses of the instruction in D
//   d_read_stage0/1  stage that consumes rs/rt (0=D, 1=E, 2=M, 3=never)
//   d_write_addr     destination register (0 = no write)
//   d_write_stage    stage whose end produces the result (0=D, 1=E, 2=M)
//   d_md_start       mult/multu/div/divu in D, d_md_div selects divide
//   d_md_use         instruction in D touches HI/LO
//   stall            hold PC and F/D, bubble into D/E
//   fwd_d0/1         D operand source: 0=GRF, 1=E, 2=M, 3=W
//   fwd_e0/1         E operand source: 0=pipeline register, 2=M, 3=W
//   fwd_m1           M store-data source: 0=pipeline register, 3=W
//   md_busy          HI/LO unit busy
interface hazard_ctrl_if;
    logic [4:0] d_read_addr0;
    logic [4:0] d_read_addr1;
    logic [1:0] d_read_stage0;
    logic [1:0] d_read_stage1;
    logic [4:0] d_write_addr;
    logic [1:0] d_write_stage;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       stall;
    logic [1:0] fwd_d0;
    logic [1:0] fwd_d1;
    logic [1:0] fwd_e0;
    logic [1:0] fwd_e1;
    logic [1:0] fwd_m1;
    logic       md_busy;

    modport master (
        output d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1,
               d_write_addr, d_write_stage, d_md_start, d_md_div, d_md_use,
        input  stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, md_busy
    );

    modport slave (
        input  d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1,
               d_write_addr, d_write_stage, d_md_start, d_md_div, d_md_use,
        output stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage (F/D/E/M/W) MIPS core.
// Shadows the decode-stage register tags through E, M and W, and from them derives the
// F/D stall, the D/E bubble, the forwarding selects and the HI/LO busy interlock.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   hz     hazard_ctrl_if slave: D-stage tags in, stall/forward/md_busy out
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef struct packed {
        logic [4:0] write_addr;
        logic [1:0] write_stage;
        logic [4:0] read_addr0;
        logic [4:0] read_addr1;
        logic       md_start;
        logic       md_div;
    } slot_t;

    slot_t           e_q, m_q, w_q, e_d;
    logic [CntW-1:0] md_cnt_q, md_cnt_d;
    logic            md_busy;
    logic            stall_data, stall_md, stall;

    // Stall if the nearest in-flight producer of ra cannot deliver before the reader needs it.
    function automatic logic op_stall(input logic [4:0] ra, input logic [1:0] rs,
                                      input slot_t e, input slot_t m, input slot_t w);
        logic st;
        st = 1'b0;
        if (ra != 5'd0) begin
            if (e.write_addr == ra) begin
                st = ({1'b0, e.write_stage} + 3'd1) > (3'd1 + {1'b0, rs});
            end else if (m.write_addr == ra) begin
                st = ({1'b0, m.write_stage} + 3'd1) > (3'd2 + {1'b0, rs});
            end else if (w.write_addr == ra) begin
                st = ({1'b0, w.write_stage} + 3'd1) > (3'd3 + {1'b0, rs});
            end
        end
        return st;
    endfunction

    // Nearest producer wins; if its result is not yet in its pipeline register, read the GRF
    // (the value is either stalled for or re-forwarded later).
    function automatic logic [1:0] fwd_d_sel(input logic [4:0] ra,
                                             input slot_t e, input slot_t m, input slot_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (ra != 5'd0) begin
            if (e.write_addr == ra) begin
                sel = (e.write_stage < 2'd1) ? 2'd1 : 2'd0;
            end else if (m.write_addr == ra) begin
                sel = (m.write_stage < 2'd2) ? 2'd2 : 2'd0;
            end else if (w.write_addr == ra) begin
                sel = (w.write_stage < 2'd3) ? 2'd3 : 2'd0;
            end
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] ra, input slot_t m, input slot_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (ra != 5'd0) begin
            if (m.write_addr == ra) begin
                sel = (m.write_stage < 2'd2) ? 2'd2 : 2'd0;
            end else if (w.write_addr == ra) begin
                sel = (w.write_stage < 2'd3) ? 2'd3 : 2'd0;
            end
        end
        return sel;
    endfunction

    assign md_busy    = (md_cnt_q != '0);
    assign stall_data = op_stall(hz.d_read_addr0, hz.d_read_stage0, e_q, m_q, w_q)
                      | op_stall(hz.d_read_addr1, hz.d_read_stage1, e_q, m_q, w_q);
    // A mult/div sitting in E has not loaded the counter yet but already owns HI/LO.
    assign stall_md   = hz.d_md_use & (md_busy | e_q.md_start);
    assign stall      = stall_data | stall_md;

    assign hz.stall   = stall;
    assign hz.md_busy = md_busy;
    assign hz.fwd_d0  = fwd_d_sel(hz.d_read_addr0, e_q, m_q, w_q);
    assign hz.fwd_d1  = fwd_d_sel(hz.d_read_addr1, e_q, m_q, w_q);
    assign hz.fwd_e0  = fwd_e_sel(e_q.read_addr0, m_q, w_q);
    assign hz.fwd_e1  = fwd_e_sel(e_q.read_addr1, m_q, w_q);
    assign hz.fwd_m1  = ((m_q.read_addr1 != 5'd0) && (w_q.write_addr == m_q.read_addr1)
                         && (w_q.write_stage < 2'd3)) ? 2'd3 : 2'd0;

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.write_addr  = hz.d_write_addr;
            e_d.write_stage = hz.d_write_stage;
            e_d.read_addr0  = hz.d_read_addr0;
            e_d.read_addr1  = hz.d_read_addr1;
            e_d.md_start    = hz.d_md_start;
            e_d.md_div      = hz.d_md_div;
        end
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_q.md_start) begin
            md_cnt_d = e_q.md_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            md_cnt_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= e_q;
            w_q      <= m_q;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Slot fields carried for completeness but not consumed in the later stages.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{m_q.read_addr0, m_q.md_start, m_q.md_div,
                                w_q.read_addr0, w_q.read_addr1, w_q.md_start, w_q.md_div};
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    typedef struct packed {
        logic [4:0] ra0;
        logic [1:0] rs0;
        logic [4:0] ra1;
        logic [1:0] rs1;
        logic [4:0] wa;
        logic [1:0] ws;
        logic       mds;
        logic       mdd;
        logic       mdu;
    } din_t;

    typedef struct packed {
        din_t        d;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    int n_tests = 0;
    int n_fail  = 0;

    din_t NOP, LW1, ADD10, ADDU1, BEQ12, JAL, JR31, ADDU5, SW5, ORI4, ADDU4, BEQ40;
    din_t ADDU0, LW0, BEQ00, DIV, MULT, MFLO;
    vec_t vecs[22];

    function automatic din_t mk(input logic [4:0] ra0, input logic [1:0] rs0,
                                input logic [4:0] ra1, input logic [1:0] rs1,
                                input logic [4:0] wa, input logic [1:0] ws,
                                input logic mds, input logic mdd, input logic mdu);
        din_t d;
        d.ra0 = ra0; d.rs0 = rs0; d.ra1 = ra1; d.rs1 = rs1;
        d.wa  = wa;  d.ws  = ws;  d.mds = mds; d.mdd = mdd; d.mdu = mdu;
        return d;
    endfunction

    // Packed expectation: {stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, md_busy}
    function automatic logic [11:0] ex(input logic s, input logic [1:0] d0, input logic [1:0] d1,
                                       input logic [1:0] e0, input logic [1:0] e1,
                                       input logic [1:0] m1, input logic b);
        return {s, d0, d1, e0, e1, m1, b};
    endfunction

    function automatic logic [11:0] outs();
        return {hz.stall, hz.fwd_d0, hz.fwd_d1, hz.fwd_e0, hz.fwd_e1, hz.fwd_m1, hz.md_busy};
    endfunction

    task automatic drive(input din_t d);
        hz.d_read_addr0  = d.ra0;
        hz.d_read_stage0 = d.rs0;
        hz.d_read_addr1  = d.ra1;
        hz.d_read_stage1 = d.rs1;
        hz.d_write_addr  = d.wa;
        hz.d_write_stage = d.ws;
        hz.d_md_start    = d.mds;
        hz.d_md_div      = d.mdd;
        hz.d_md_use      = d.mdu;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one D-stage instruction for a cycle; outputs are settled 2 time units later.
    task automatic step(input din_t d, input logic rst);
        @(negedge clk);
        reset = rst;
        drive(d);
        #2;
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(NOP, 1'b0);
    endtask

    // Issue a mult/div, then hold mflo in D until it is released.
    task automatic md_seq(input din_t op, input int busy_exp, input string name);
        int busy_n;
        int stall_n;
        bit done;
        flush();
        step(op, 1'b0);
        check({name, " issue"}, 32'(outs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        step(MFLO, 1'b0);
        check({name, " mflo vs E"}, 32'(outs()), 32'(ex(1, 0, 0, 0, 0, 0, 0)));
        busy_n  = 0;
        stall_n = 1;
        done    = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(MFLO, 1'b0);
            if (hz.stall) begin
                stall_n++;
                if (hz.md_busy) busy_n++;
            end else begin
                done = 1'b1;
                check({name, " release"}, 32'(outs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
            end
        end
        check({name, " released in time"}, 32'(done), 32'd1);
        check({name, " busy cycles"}, 32'(busy_n), 32'(busy_exp));
        check({name, " stall cycles"}, 32'(stall_n), 32'(busy_exp + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          ra0 rs0 ra1 rs1 wa  ws  mds mdd mdu
        NOP   = mk(0,  3,  0,  3,  0,  0,  0,  0,  0);
        LW1   = mk(0,  1,  0,  3,  1,  2,  0,  0,  0);
        ADD10 = mk(1,  1,  3,  1,  10, 1,  0,  0,  0);
        ADDU1 = mk(6,  1,  7,  1,  1,  1,  0,  0,  0);
        BEQ12 = mk(1,  0,  2,  0,  0,  0,  0,  0,  0);
        JAL   = mk(0,  3,  0,  3,  31, 0,  0,  0,  0);
        JR31  = mk(31, 0,  0,  3,  0,  0,  0,  0,  0);
        ADDU5 = mk(6,  1,  7,  1,  5,  1,  0,  0,  0);
        SW5   = mk(0,  1,  5,  2,  0,  0,  0,  0,  0);
        ORI4  = mk(0,  1,  0,  3,  4,  1,  0,  0,  0);
        ADDU4 = mk(8,  1,  9,  1,  4,  1,  0,  0,  0);
        BEQ40 = mk(4,  0,  0,  0,  0,  0,  0,  0,  0);
        ADDU0 = mk(8,  1,  9,  1,  0,  1,  0,  0,  0);
        LW0   = mk(0,  1,  0,  3,  0,  2,  0,  0,  0);
        BEQ00 = mk(0,  0,  0,  0,  0,  0,  0,  0,  0);
        DIV   = mk(8,  1,  9,  1,  0,  0,  1,  1,  1);
        MULT  = mk(8,  1,  9,  1,  0,  0,  1,  0,  1);
        MFLO  = mk(0,  3,  0,  3,  3,  1,  0,  0,  1);

        vecs[0]  = '{NOP,   ex(0, 0, 0, 0, 0, 0, 0)};  // state right after reset
        vecs[1]  = '{LW1,   ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{ADD10, ex(1, 0, 0, 0, 0, 0, 0)};  // load-use: lw in E
        vecs[3]  = '{ADD10, ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{NOP,   ex(0, 0, 0, 3, 0, 0, 0)};  // add in E takes $1 from W
        vecs[5]  = '{ADDU1, ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{BEQ12, ex(1, 0, 0, 0, 0, 0, 0)};  // branch needs ALU result in D
        vecs[7]  = '{BEQ12, ex(0, 2, 0, 0, 0, 0, 0)};
        vecs[8]  = '{JAL,   ex(0, 0, 0, 3, 0, 0, 0)};
        vecs[9]  = '{JR31,  ex(0, 1, 0, 0, 0, 0, 0)};  // jal link forwarded from E
        vecs[10] = '{ADDU5, ex(0, 0, 0, 2, 0, 0, 0)};
        vecs[11] = '{SW5,   ex(0, 0, 0, 0, 0, 0, 0)};  // store data needed only in M
        vecs[12] = '{NOP,   ex(0, 0, 0, 0, 2, 0, 0)};
        vecs[13] = '{ORI4,  ex(0, 0, 0, 0, 0, 3, 0)};
        vecs[14] = '{ADDU4, ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[15] = '{BEQ40, ex(1, 0, 0, 0, 0, 0, 0)};
        vecs[16] = '{BEQ40, ex(0, 2, 0, 0, 0, 0, 0)};  // newer producer in M shadows W
        vecs[17] = '{NOP,   ex(0, 0, 0, 3, 0, 0, 0)};
        vecs[18] = '{ADDU0, ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[19] = '{LW0,   ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[20] = '{BEQ00, ex(0, 0, 0, 0, 0, 0, 0)};  // $0 never a hazard
        vecs[21] = '{NOP,   ex(0, 0, 0, 0, 0, 0, 0)};

        reset = 1'b1;
        drive(NOP);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].d, 1'b0);
            check($sformatf("row %0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        md_seq(DIV, 10, "div");
        md_seq(MULT, 5, "mult");

        // Reset during a divide drops the busy counter.
        flush();
        step(DIV, 1'b0);
        step(NOP, 1'b0);
        step(NOP, 1'b0);
        check("div busy before reset", 32'(outs()), 32'(ex(0, 0, 0, 0, 0, 0, 1)));
        step(NOP, 1'b1);
        step(MFLO, 1'b0);
        check("mflo after reset mid-div", 32'(outs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));

        // Reset during a data stall drops the pending producer.
        flush();
        step(ADDU1, 1'b0);
        step(BEQ12, 1'b1);
        check("stall before reset", 32'(outs()), 32'(ex(1, 0, 0, 0, 0, 0, 0)));
        step(BEQ12, 1'b0);
        check("beq after reset mid-stall", 32'(outs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the five-stage MIPS core (F/D/E/M/W).
- Takes the decode stage's per-instruction read/write stage tags and keeps its own copy of them as the instruction moves through E, M and W.
- Produces the F/D stall, the E bubble and the forwarding selects for D, E and M operands.
- Also runs the HI/LO multiply/divide busy counter and stalls HI/LO users while it is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu starts in E.
- DIV_CYCLES, 10, busy cycles after a div/divu starts in E.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- d_read_addr0  in  5  rs address of the instruction in D.
- d_read_addr1  in  5  rt address of the instruction in D.
- d_read_stage0  in  2  stage that needs rs: 0=D, 1=E, 2=M, 3=never.
- d_read_stage1  in  2  stage that needs rt, same encoding.
- d_write_addr  in  5  destination register; 0 means no write.
- d_write_stage  in  2  stage whose end produces the result: 0=D, 1=E, 2=M.
- d_md_start  in  1  instruction in D is mult/multu/div/divu.
- d_md_div  in  1  qualifies d_md_start: 1=div, 0=mult.
- d_md_use  in  1  instruction in D uses HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  hold PC and the F/D register, and load a bubble into D/E.
- fwd_d0  out  2  rs source in D: 0=GRF, 1=E, 2=M, 3=W.
- fwd_d1  out  2  rt source in D, same encoding.
- fwd_e0  out  2  rs source in E: 0=pipeline register, 2=M, 3=W.
- fwd_e1  out  2  rt source in E, same encoding.
- fwd_m1  out  2  rt (store data) source in M: 0=pipeline register, 3=W.
- md_busy  out  1  HI/LO unit is busy.

Behaviour:
- Internal slots E, M, W each hold: write_addr[4:0], write_stage[1:0], read_addr0/1, md_start, md_div.
- Slot stage index s: E=1, M=2, W=3.
- Every cycle the slots advance: W<=M, M<=E.
- E<=D fields when stall=0. When stall=1, E<=bubble (all fields zero).
- Reset: all slots zero, busy counter zero. Every output is 0 in the cycle after reset.
- Asserting reset mid-stall or mid-multiply drops all pending state.
- Producer match for operand k against slot X: X.write_addr==d_read_addr_k and d_read_addr_k!=0.
- Data stall:
  - Stall when any matching producer has (X.write_stage + 1) > (s + d_read_stage_k).
  - A read stage of 3 never stalls (3+s >= 4 > w+1 always).
  - Only the nearest matching slot counts for each operand; a newer producer shadows an older one.
- MD stall:
  - Asserted when d_md_use && (md_busy || E.md_start).
- stall = data stall OR MD stall. Purely combinational from D inputs and the slots.
- Forward selects:
  - Pick the nearest matching slot, searched in order E, M, W for D operands and M, W for E operands.
  - Each slot is a candidate only if X.write_stage < s, i.e. its result already sits in that slot's pipeline register.
  - No matching candidate gives select 0.
  - fwd_m1 is 3 iff W matches M.read_addr1 (nonzero) and W.write_stage < 3.
  - fwd_d* may be nonzero while stall=1; the datapath ignores them in that cycle.
- MD busy counter:
  - When E.md_start=1, counter <= (E.md_div ? DIV_CYCLES : MULT_CYCLES).
  - Otherwise, if counter != 0, it decrements by 1.
  - md_busy = (counter != 0).
  - A new md_start while busy cannot happen, because the MD stall blocks it in D.
- The register-0 write is never a hazard. A write_stage=0 producer (jal/jalr) is forwardable from E with no stall.

Test Plan:
- lw $1 then add $2,$1,$3:
  - lw in E: stall=1 for exactly 1 cycle.
  - Next cycle: fwd_e0=3 (from W).
- addu $1 then beq $1,$2:
  - stall=1 for 1 cycle (addu in E).
  - Then fwd_d0=2 (from M) with stall=0.
- jal then jr $31: stall=0 and fwd_d0=1 (from E).
- addu $5 then sw $5,0($0):
  - stall=0, fwd_e1=2.
  - Next cycle fwd_m1=3.
- Shadowing and register 0:
  - ori $4 then addu $4 then beq $4: forwards from the newer producer.
  - Any write to $0 followed by reads of $0: stall=0 and all selects 0.
- MD timing:
  - div enters E: md_busy high for 10 cycles.
  - A following mflo stalls until the cycle md_busy falls; MULT_CYCLES=5 gives 5 cycles for mult.
  - Reset asserted on cycle 3 of the div: md_busy=0 and stall=0 on the next cycle.
